decode_mc: RTL and testbench
============================

Name: decode_mc

Overview:
- Next-generation control unit for the multicycle ARM-subset processor.
- Integrates the main control FSM, an extended ALU decoder, the PC logic and the instruction decoder.
- Adds EOR/RSB/MOV/BIC, flag-only compares (CMP/CMN/TST) and a multi-cycle MUL path that drives an external iterative multiplier.
- Sits between the instruction register/flag logic and the datapath muxes and enables.

Parameters:
ALUCTRL_W, 3, ALUControl width; must be >=3; bits above [2] are driven 0.
MUL_CYCLES, 4, multiplier latency in cycles (>=1); MULEXEC lasts exactly MUL_CYCLES cycles.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
Op  input  2  Instr[27:26].
Funct  input  6  Instr[25:20]; [5]=I, [4:1]=cmd, [0]=S.
Rd  input  4  Instr[15:12].
MulOp  input  1  Instr[7:4]==4'b1001.
FlagW  output  2  [1]=write NZ, [0]=write CV.
PCS  output  1  PC written from the result path.
NextPC  output  1  PC update in FETCH.
RegW  output  1  register write enable (pre-condition).
MemW  output  1  memory write enable (pre-condition).
IRWrite  output  1  instruction register load.
AdrSrc  output  1  0=PC, 1=ALU result.
ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult, 11=MulProduct.
ALUSrcA  output  2  00=RA, 01=PC.
ALUSrcB  output  2  00=RD2, 01=ExtImm, 10=constant 4.
ImmSrc  output  2  immediate format.
RegSrc  output  2  register-address selects.
ALUControl  output  ALUCTRL_W  ALU operation.
MulStart  output  1  one-cycle start pulse to the multiplier.
MulBusy  output  1  high throughout MULEXEC.
MulRdSel  output  1  write address taken from Instr[19:16] (MUL Rd field).

Behaviour:
- Reset: state=FETCH, mul counter=0.
- While reset is high, IRWrite, NextPC, RegW, MemW, MulStart and PCS are forced 0; all muxes take their FETCH values.
- Reset asserted mid-instruction aborts it; the first cycle after deassertion is FETCH.
- FSM states (Moore outputs; any output not listed is 0):
  - FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10. Next state: DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
    - Op=01 -> MEMADR.
    - Op=10 -> BRANCH.
    - Op=00 & MulOp & Funct[5:4]==00 -> MULEXEC.
    - Op=00 & Funct[5]=0 -> EXECUTER.
    - Op=00 & Funct[5]=1 -> EXECUTEI.
    - Op=11 -> FETCH (NOP).
  - MEMADR: ALUSrcA=00, ALUSrcB=01. Funct[0]=1 -> MEMRD; otherwise -> MEMWR.
  - MEMRD: AdrSrc=1 -> MEMWB.
  - MEMWB: ResultSrc=01, RegW=1 -> FETCH.
  - MEMWR: AdrSrc=1, MemW=1 -> FETCH.
  - EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUOp=1 -> ALUWB.
  - EXECUTEI: ALUSrcA=00, ALUSrcB=01, ALUOp=1 -> ALUWB.
  - ALUWB: ResultSrc=00, RegW = ~NoWrite -> FETCH.
  - BRANCH: ALUSrcA=00, ALUSrcB=01, ResultSrc=10, Branch=1 -> FETCH.
  - MULEXEC: MulBusy=1; MulStart=1 on entry cycle only.
    - Counter loads MUL_CYCLES-1 on entry and decrements each cycle; at 0 -> MULWB.
    - MUL_CYCLES=1 gives a single MULEXEC cycle.
  - MULWB: ResultSrc=11, RegW=1, MulRdSel=1, counter cleared -> FETCH.
- ALU decoder (ALUOp=1 only; internal ALUOp is high in EXECUTER/EXECUTEI; ALUControl shown as its low 3 bits):
  - cmd 0100 ADD=000, 0010 SUB=001, 0000 AND=010, 1100 ORR=011, 0001 EOR=100, 0011 RSB=101, 1101 MOV=110, 1110 BIC=111.
  - 1010 CMP=001 with NoWrite=1; 1011 CMN=000 with NoWrite=1; 1000 TST=010 with NoWrite=1.
  - Any other cmd: ALUControl=000, FlagW=00, NoWrite=1 (instruction is a no-op).
- FlagW (ALUOp=1):
  - FlagW[1] = Funct[0].
  - FlagW[0] = Funct[0] & (ALUControl in {000,001,101}).
- ALUOp=0: ALUControl=000, FlagW=00, NoWrite=0.
- PC logic: PCS = ((Rd==4'hF) & RegW & ~MulRdSel) | Branch; a MUL to R15 never sets PCS.
- Instr decoder (combinational): ImmSrc=Op; RegSrc[0]=(Op==10); RegSrc[1]=(Op==01).

Test Plan:
- Reset asserted mid-MULEXEC (MUL_CYCLES=4, cycle 2), released -> next cycle FETCH with IRWrite=1; MulBusy=0, MulStart=0 throughout reset.
- ADD R1,R2,R3 (Op=00, Funct=001000, Rd=1) -> FETCH, DECODE, EXECUTER (ALUControl=000, FlagW=00), ALUWB (RegW=1, PCS=0); 4 cycles total.
- CMP Funct=010101 (I=0) -> EXECUTER ALUControl=001, FlagW=11; ALUWB RegW=0. Undefined cmd 0111 -> ALUWB RegW=0, FlagW=00.
- LDR to R15 (Op=01, Funct[0]=1, Rd=F) -> MEMADR, MEMRD (AdrSrc=1), MEMWB (ResultSrc=01, RegW=1, PCS=1); STR -> MEMWR MemW=1, 4 cycles total.
- MUL (Op=00, Funct=000000, MulOp=1), MUL_CYCLES=4 and MUL_CYCLES=1 -> MulStart high exactly 1 cycle; MulBusy high exactly 4 (resp. 1) cycles; then MULWB ResultSrc=11, RegW=1, MulRdSel=1, PCS=0 with Rd=F.
- Branch (Op=10) -> BRANCH: Branch=1, PCS=1, ALUSrcB=01, RegSrc=01. Op=11 -> DECODE goes straight to FETCH with no write enable asserted.

Source files
------------

// File: rtl/decode_mc.sv
// decode_mc -- control unit for the multicycle ARM-subset core.
// Main control FSM, ALU decoder, PC-write logic and instruction decoder,
// including flag-only compares and a multi-cycle MUL path that drives an
// external iterative multiplier.
//
// Ports:
//   clk, reset         clock / async active-high reset
//   Op, Funct, Rd      instruction fields Instr[27:26], [25:20], [15:12]
//   MulOp              Instr[7:4] == 4'b1001
//   FlagW              [1]=write NZ, [0]=write CV
//   PCS, NextPC        PC written from result path / PC update in FETCH
//   RegW, MemW         register / memory write enables (pre-condition)
//   IRWrite            instruction register load
//   AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc   datapath selects
//   ALUControl         ALU operation (bits above [2] are 0)
//   MulStart, MulBusy  multiplier start pulse / busy during MULEXEC
//   MulRdSel           write address from Instr[19:16] (MUL Rd field)
module decode_mc #(
  parameter int ALUCTRL_W  = 3,
  parameter int MUL_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           Op,
  input  logic [5:0]           Funct,
  input  logic [3:0]           Rd,
  input  logic                 MulOp,
  output logic [1:0]           FlagW,
  output logic                 PCS,
  output logic                 NextPC,
  output logic                 RegW,
  output logic                 MemW,
  output logic                 IRWrite,
  output logic                 AdrSrc,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 MulStart,
  output logic                 MulBusy,
  output logic                 MulRdSel
);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECUTER, EXECUTEI, ALUWB, BRANCH, MULEXEC, MULWB
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;

  // internal (pre-reset-gating) enables
  logic ir_w, npc, reg_w, mem_w, branch, alu_op;
  // ALU decoder results
  logic [2:0] alu3;
  logic       cmd_def, no_write;

  // ---------------- state and multiply counter ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (state == DECODE && state_n == MULEXEC)
        cnt <= CNT_LOAD;
      else if (state == MULEXEC && cnt != '0)
        cnt <= cnt - CNT_W'(1);
      else if (state == MULWB)
        cnt <= '0;
    end
  end

  // ---------------- ALU decoder (command field only) ----------------
  always_comb begin
    alu3     = 3'b000;
    cmd_def  = 1'b1;
    no_write = 1'b0;
    case (Funct[4:1])
      4'b0100: alu3 = 3'b000;                     // ADD
      4'b0010: alu3 = 3'b001;                     // SUB
      4'b0000: alu3 = 3'b010;                     // AND
      4'b1100: alu3 = 3'b011;                     // ORR
      4'b0001: alu3 = 3'b100;                     // EOR
      4'b0011: alu3 = 3'b101;                     // RSB
      4'b1101: alu3 = 3'b110;                     // MOV
      4'b1110: alu3 = 3'b111;                     // BIC
      4'b1010: begin alu3 = 3'b001; no_write = 1'b1; end  // CMP
      4'b1011: begin alu3 = 3'b000; no_write = 1'b1; end  // CMN
      4'b1000: begin alu3 = 3'b010; no_write = 1'b1; end  // TST
      default: begin cmd_def = 1'b0; no_write = 1'b1; end // treated as no-op
    endcase
  end

  // ---------------- next state and Moore outputs ----------------
  always_comb begin
    state_n   = state;
    ir_w      = 1'b0;
    npc       = 1'b0;
    reg_w     = 1'b0;
    mem_w     = 1'b0;
    branch    = 1'b0;
    alu_op    = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    MulBusy   = 1'b0;
    MulStart  = 1'b0;
    MulRdSel  = 1'b0;
    case (state)
      FETCH: begin
        ir_w = 1'b1; npc = 1'b1;
        ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        state_n = DECODE;
      end
      DECODE: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        case (Op)
          2'b01:   state_n = MEMADR;
          2'b10:   state_n = BRANCH;
          2'b00: begin
            if (MulOp && Funct[5:4] == 2'b00) state_n = MULEXEC;
            else if (Funct[5])                state_n = EXECUTEI;
            else                              state_n = EXECUTER;
          end
          default: state_n = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
        state_n = Funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin AdrSrc = 1'b1; state_n = MEMWB; end
      MEMWB: begin ResultSrc = 2'b01; reg_w = 1'b1; state_n = FETCH; end
      MEMWR: begin AdrSrc = 1'b1; mem_w = 1'b1; state_n = FETCH; end
      EXECUTER: begin alu_op = 1'b1; state_n = ALUWB; end
      EXECUTEI: begin ALUSrcB = 2'b01; alu_op = 1'b1; state_n = ALUWB; end
      // Funct is held by the IR, so the no-write decode is still valid here
      ALUWB: begin reg_w = ~no_write; state_n = FETCH; end
      BRANCH: begin
        ALUSrcB = 2'b01; ResultSrc = 2'b10; branch = 1'b1;
        state_n = FETCH;
      end
      MULEXEC: begin
        MulBusy = 1'b1;
        // counter only counts down, so the load value marks the entry cycle
        MulStart = (cnt == CNT_LOAD);
        if (cnt == '0) state_n = MULWB;
      end
      MULWB: begin
        ResultSrc = 2'b11; reg_w = 1'b1; MulRdSel = 1'b1;
        state_n = FETCH;
      end
      default: state_n = FETCH;
    endcase
  end

  // ---------------- ALU control / flags ----------------
  always_comb begin
    ALUControl = '0;
    FlagW      = 2'b00;
    if (alu_op) begin
      ALUControl[2:0] = alu3;
      if (cmd_def)
        FlagW = {Funct[0],
                 Funct[0] & (alu3 == 3'b000 || alu3 == 3'b001 || alu3 == 3'b101)};
    end
  end

  // ---------------- enables, gated off while in reset ----------------
  assign IRWrite = ir_w  & ~reset;
  assign NextPC  = npc   & ~reset;
  assign RegW    = reg_w & ~reset;
  assign MemW    = mem_w & ~reset;
  // a MUL writing R15 must not redirect the PC
  assign PCS     = (((Rd == 4'hF) & reg_w & ~MulRdSel) | branch) & ~reset;

  // ---------------- instruction decoder ----------------
  assign ImmSrc = Op;
  assign RegSrc = {Op == 2'b01, Op == 2'b10};

endmodule

// File: tb/tb_decode_mc.sv
module tb_decode_mc;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       MulOp;

  // instance a: MUL_CYCLES=4, instance b: MUL_CYCLES=1
  logic [1:0] FlagW_a, ResultSrc_a, ALUSrcA_a, ALUSrcB_a, ImmSrc_a, RegSrc_a;
  logic [2:0] ALUControl_a;
  logic PCS_a, NextPC_a, RegW_a, MemW_a, IRWrite_a, AdrSrc_a, MulStart_a, MulBusy_a, MulRdSel_a;
  logic [1:0] FlagW_b, ResultSrc_b, ALUSrcA_b, ALUSrcB_b, ImmSrc_b, RegSrc_b;
  logic [2:0] ALUControl_b;
  logic PCS_b, NextPC_b, RegW_b, MemW_b, IRWrite_b, AdrSrc_b, MulStart_b, MulBusy_b, MulRdSel_b;

  typedef struct packed {
    logic [1:0] flagw;
    logic       pcs, nextpc, regw, memw, irwrite, adrsrc;
    logic [1:0] resultsrc, alusrca, alusrcb, immsrc, regsrc;
    logic [2:0] aluctl;
    logic       mulstart, mulbusy, mulrdsel;
  } outs_t;

  outs_t act_a, act_b;
  outs_t seq[$];
  outs_t exp_a[$], exp_b[$];
  int n_chk = 0;
  int n_fail = 0;

  decode_mc #(.ALUCTRL_W(3), .MUL_CYCLES(4)) u_a (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .MulOp(MulOp),
    .FlagW(FlagW_a), .PCS(PCS_a), .NextPC(NextPC_a), .RegW(RegW_a), .MemW(MemW_a),
    .IRWrite(IRWrite_a), .AdrSrc(AdrSrc_a), .ResultSrc(ResultSrc_a), .ALUSrcA(ALUSrcA_a),
    .ALUSrcB(ALUSrcB_a), .ImmSrc(ImmSrc_a), .RegSrc(RegSrc_a), .ALUControl(ALUControl_a),
    .MulStart(MulStart_a), .MulBusy(MulBusy_a), .MulRdSel(MulRdSel_a));

  decode_mc #(.ALUCTRL_W(3), .MUL_CYCLES(1)) u_b (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .MulOp(MulOp),
    .FlagW(FlagW_b), .PCS(PCS_b), .NextPC(NextPC_b), .RegW(RegW_b), .MemW(MemW_b),
    .IRWrite(IRWrite_b), .AdrSrc(AdrSrc_b), .ResultSrc(ResultSrc_b), .ALUSrcA(ALUSrcA_b),
    .ALUSrcB(ALUSrcB_b), .ImmSrc(ImmSrc_b), .RegSrc(RegSrc_b), .ALUControl(ALUControl_b),
    .MulStart(MulStart_b), .MulBusy(MulBusy_b), .MulRdSel(MulRdSel_b));

  assign act_a = {FlagW_a, PCS_a, NextPC_a, RegW_a, MemW_a, IRWrite_a, AdrSrc_a,
                  ResultSrc_a, ALUSrcA_a, ALUSrcB_a, ImmSrc_a, RegSrc_a, ALUControl_a,
                  MulStart_a, MulBusy_a, MulRdSel_a};
  assign act_b = {FlagW_b, PCS_b, NextPC_b, RegW_b, MemW_b, IRWrite_b, AdrSrc_b,
                  ResultSrc_b, ALUSrcA_b, ALUSrcB_b, ImmSrc_b, RegSrc_b, ALUControl_b,
                  MulStart_b, MulBusy_b, MulRdSel_b};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic outs_t base_o();
    outs_t o = '0;
    o.immsrc = Op;
    o.regsrc = {Op == 2'b01, Op == 2'b10};
    return o;
  endfunction

  function automatic outs_t fetch_o();
    outs_t o = base_o();
    o.irwrite = 1'b1; o.nextpc = 1'b1;
    o.alusrca = 2'b01; o.alusrcb = 2'b10; o.resultsrc = 2'b10;
    return o;
  endfunction

  // data-processing command table: ALU code, writes register, defined
  function automatic void cmd_info(input logic [3:0] c, output logic [2:0] ctl,
                                   output bit wr, output bit known);
    known = 1; wr = 1; ctl = 3'd0;
    case (c)
      4'h4: ctl = 3'd0;  4'h2: ctl = 3'd1;  4'h0: ctl = 3'd2;  4'hC: ctl = 3'd3;
      4'h1: ctl = 3'd4;  4'h3: ctl = 3'd5;  4'hD: ctl = 3'd6;  4'hE: ctl = 3'd7;
      4'hA: begin ctl = 3'd1; wr = 0; end
      4'hB: begin ctl = 3'd0; wr = 0; end
      4'h8: begin ctl = 3'd2; wr = 0; end
      default: begin known = 0; wr = 0; end
    endcase
  endfunction

  // per-cycle expected outputs of one instruction, plus the following FETCH
  task automatic build(input int mc);
    outs_t o;
    logic [2:0] ctl;
    bit wr, known;
    seq.delete();
    seq.push_back(fetch_o());
    o = base_o(); o.alusrca = 2'b01; o.alusrcb = 2'b10; o.resultsrc = 2'b10;
    seq.push_back(o);
    if (Op == 2'b01) begin
      o = base_o(); o.alusrcb = 2'b01; seq.push_back(o);
      if (Funct[0]) begin
        o = base_o(); o.adrsrc = 1; seq.push_back(o);
        o = base_o(); o.resultsrc = 2'b01; o.regw = 1; o.pcs = (Rd == 4'hF); seq.push_back(o);
      end else begin
        o = base_o(); o.adrsrc = 1; o.memw = 1; seq.push_back(o);
      end
    end else if (Op == 2'b10) begin
      o = base_o(); o.alusrcb = 2'b01; o.resultsrc = 2'b10; o.pcs = 1; seq.push_back(o);
    end else if (Op == 2'b00) begin
      if (MulOp && Funct[5:4] == 2'b00) begin
        for (int k = 0; k < mc; k++) begin
          o = base_o(); o.mulbusy = 1; o.mulstart = (k == 0); seq.push_back(o);
        end
        o = base_o(); o.resultsrc = 2'b11; o.regw = 1; o.mulrdsel = 1; seq.push_back(o);
      end else begin
        cmd_info(Funct[4:1], ctl, wr, known);
        o = base_o();
        o.alusrcb = Funct[5] ? 2'b01 : 2'b00;
        o.aluctl = ctl;
        if (known) o.flagw = {Funct[0], Funct[0] & (ctl inside {3'd0, 3'd1, 3'd5})};
        seq.push_back(o);
        o = base_o(); o.regw = wr; o.pcs = wr && (Rd == 4'hF); seq.push_back(o);
      end
    end
    seq.push_back(fetch_o());
  endtask

  // reset, then step one instruction on both instances against the model
  task automatic run_instr(input string name, input logic [1:0] op, input logic [5:0] fn,
                           input logic [3:0] rd, input logic mo);
    outs_t r;
    int n;
    @(negedge clk);
    Op = op; Funct = fn; Rd = rd; MulOp = mo; reset = 1'b1;
    #1;
    r = fetch_o(); r.irwrite = 0; r.nextpc = 0;
    chk({name, "_rst_a"}, 64'(act_a), 64'(r));
    chk({name, "_rst_b"}, 64'(act_b), 64'(r));
    build(4); exp_a = seq;
    build(1); exp_b = seq;
    n = (exp_a.size() > exp_b.size()) ? exp_a.size() : exp_b.size();
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      if (i < exp_a.size()) chk($sformatf("%s_a[%0d]", name, i), 64'(act_a), 64'(exp_a[i]));
      if (i < exp_b.size()) chk($sformatf("%s_b[%0d]", name, i), 64'(act_b), 64'(exp_b[i]));
    end
  endtask

  initial begin
    reset = 1'b1; Op = 2'b00; Funct = 6'd0; Rd = 4'd0; MulOp = 1'b0;
    @(negedge clk); #1;
    chk("init_irwrite", 64'(IRWrite_a), 64'd0);
    chk("init_alusrcb", 64'(ALUSrcB_a), 64'd2);

    // reset in the middle of a 4-cycle multiply
    @(negedge clk);
    Op = 2'b00; Funct = 6'b000000; Rd = 4'hF; MulOp = 1'b1;
    reset = 1'b0;                         // FETCH
    @(negedge clk);                       // DECODE
    @(negedge clk); #1;                   // MULEXEC 1
    chk("mid_mulstart1", 64'(MulStart_a), 64'd1);
    @(negedge clk); #1;                   // MULEXEC 2
    chk("mid_mulbusy2", 64'(MulBusy_a), 64'd1);
    chk("mid_mulstart2", 64'(MulStart_a), 64'd0);
    reset = 1'b1; #1;
    chk("mid_rst_busy", 64'(MulBusy_a), 64'd0);
    chk("mid_rst_start", 64'(MulStart_a), 64'd0);
    chk("mid_rst_irw", 64'(IRWrite_a), 64'd0);
    @(negedge clk); #1;
    chk("mid_rst2_busy", 64'(MulBusy_a), 64'd0);
    chk("mid_rst2_start", 64'(MulStart_a), 64'd0);
    reset = 1'b0; #1;
    chk("mid_rel_irw", 64'(IRWrite_a), 64'd1);
    chk("mid_rel_fetch", 64'(act_a), 64'(fetch_o()));

    // directed instructions
    run_instr("add",    2'b00, 6'b001000, 4'h1, 1'b0);
    run_instr("cmp",    2'b00, 6'b010101, 4'h2, 1'b0);
    run_instr("undef",  2'b00, 6'b001111, 4'h3, 1'b0);
    run_instr("eor_i",  2'b00, 6'b100011, 4'hF, 1'b0);
    run_instr("ldr_pc", 2'b01, 6'b000001, 4'hF, 1'b0);
    run_instr("str",    2'b01, 6'b000000, 4'h4, 1'b0);
    run_instr("mul_pc", 2'b00, 6'b000000, 4'hF, 1'b1);
    run_instr("branch", 2'b10, 6'b000000, 4'h0, 1'b0);
    run_instr("nop",    2'b11, 6'b111111, 4'hF, 1'b1);

    // randomized instructions
    for (int t = 0; t < 80; t++) begin
      logic [5:0] fn;
      fn = 6'($urandom);
      if ($urandom_range(0, 3) == 0) fn[5:4] = 2'b00;
      run_instr($sformatf("rnd%0d", t), 2'($urandom_range(0, 3)), fn,
                ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
